// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_e : sequencer FSM states
//   cnt_width   : width of the hold/stagger down-counter
package reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        RELEASE,
        ASSERT,
        DONE
    } seq_state_e;

    // Enough bits to hold the larger of the two programmable cycle counts.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned stagger_cycles);
        int unsigned max_cycles;
        max_cycles = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Reset synchroniser: asserts asynchronously, deasserts synchronously after
// SYNC_STAGES rising edges of clk with async_reset_n high.
//   clk           : destination clock
//   async_reset_n : asynchronous reset, active-low
//   rst_sync_out  : synchronised reset, active-high
module reset_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic async_reset_n,
    output logic rst_sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift zeros in from stage 0; the last stage is the output.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises an async reset, holds for HOLD_CYCLES, then
// releases NUM_DOMAINS reset outputs in order (domain 0 first), STAGGER_CYCLES
// apart. A software request in DONE re-resets every domain without SYNC.
// Optional macro RST_SEQ_ORDERED_ASSERT_EN: software re-reset asserts domains
// in reverse order, STAGGER_CYCLES apart, acking when domain 0 asserts.
//   clk           : system clock
//   async_reset_n : asynchronous reset, active-low
//   sw_reset_req  : software re-reset request, level-sampled
//   sw_reset_ack  : one-cycle pulse when a request completes its assertion
//   domain_reset  : per-domain reset, active-high
//   reset_done    : high once every domain is released
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   async_reset_n,
    input  logic                   sw_reset_req,
    output logic                   sw_reset_ack,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   reset_done
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_DOMAINS) + 1;

    logic                   rst_sync;
    seq_state_e             state_q,        state_d;
    logic [CNT_W-1:0]       cnt_q,          cnt_d;
    logic [IDX_W-1:0]       idx_q,          idx_d;
    logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_d;
    logic                   reset_done_q,   reset_done_d;
    logic                   sw_reset_ack_q, sw_reset_ack_d;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .rst_sync_out  (rst_sync)
    );

    // cnt counts edges remaining until the next domain event; the event fires
    // on the edge where cnt is 1. The SYNC exit edge is the first hold cycle.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        domain_reset_d = domain_reset_q;
        reset_done_d   = reset_done_q;
        sw_reset_ack_d = 1'b0;

        case (state_q)
            SYNC: begin
                if (!rst_sync) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d           = RELEASE;
                        domain_reset_d[0] = 1'b0;
                        idx_d             = IDX_W'(1);
                        cnt_d             = CNT_W'(STAGGER_CYCLES);
                    end else begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    end
                end
            end

            HOLD: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d           = RELEASE;
                    domain_reset_d[0] = 1'b0;
                    idx_d             = IDX_W'(1);
                    cnt_d             = CNT_W'(STAGGER_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RELEASE: begin
                if (idx_q == IDX_W'(NUM_DOMAINS)) begin
                    state_d      = DONE;
                    reset_done_d = 1'b1;
                end else if (cnt_q == CNT_W'(1)) begin
                    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
                        if (idx_q == IDX_W'(i)) domain_reset_d[i] = 1'b0;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = CNT_W'(STAGGER_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

`ifdef RST_SEQ_ORDERED_ASSERT_EN
            // Reverse-order assertion; idx is the next domain to assert.
            ASSERT: begin
                if (cnt_q == CNT_W'(1)) begin
                    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
                        if (idx_q == IDX_W'(i)) domain_reset_d[i] = 1'b1;
                    end
                    if (idx_q == '0) begin
                        sw_reset_ack_d = 1'b1;
                        state_d        = HOLD;
                        cnt_d          = CNT_W'(HOLD_CYCLES);
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        cnt_d = CNT_W'(STAGGER_CYCLES);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif

            DONE: begin
                if (sw_reset_req) begin
                    reset_done_d = 1'b0;
`ifdef RST_SEQ_ORDERED_ASSERT_EN
                    domain_reset_d[NUM_DOMAINS-1] = 1'b1;
                    if (NUM_DOMAINS == 1) begin
                        sw_reset_ack_d = 1'b1;
                        state_d        = HOLD;
                        cnt_d          = CNT_W'(HOLD_CYCLES);
                    end else begin
                        state_d = ASSERT;
                        idx_d   = IDX_W'(NUM_DOMAINS - 2);
                        cnt_d   = CNT_W'(STAGGER_CYCLES);
                    end
`else
                    domain_reset_d = '1;
                    sw_reset_ack_d = 1'b1;
                    state_d        = HOLD;
                    cnt_d          = CNT_W'(HOLD_CYCLES);
`endif
                end
            end

            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q        <= SYNC;
            cnt_q          <= '0;
            idx_q          <= '0;
            domain_reset_q <= '1;
            reset_done_q   <= 1'b0;
            sw_reset_ack_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            domain_reset_q <= domain_reset_d;
            reset_done_q   <= reset_done_d;
            sw_reset_ack_q <= sw_reset_ack_d;
        end
    end

    assign domain_reset = domain_reset_q;
    assign reset_done   = reset_done_q;
    assign sw_reset_ack = sw_reset_ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a single-domain
// instance (NUM_DOMAINS=1, HOLD_CYCLES=1, SYNC_STAGES=3).
module tb_reset_sequencer;

    logic       clk;
    logic       async_reset_n;
    logic       sw_reset_req;
    logic       sw_reset_ack;
    logic [3:0] domain_reset;
    logic       reset_done;

    logic       rst1_n;
    logic       req1;
    logic       ack1;
    logic [0:0] dr1;
    logic       done1;

    int checks = 0;
    int passed = 0;
    int edge_cnt = 0;

    reset_sequencer dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .sw_reset_req  (sw_reset_req),
        .sw_reset_ack  (sw_reset_ack),
        .domain_reset  (domain_reset),
        .reset_done    (reset_done)
    );

    reset_sequencer #(
        .NUM_DOMAINS    (1),
        .SYNC_STAGES    (3),
        .HOLD_CYCLES    (1),
        .STAGGER_CYCLES (4)
    ) dut1 (
        .clk           (clk),
        .async_reset_n (rst1_n),
        .sw_reset_req  (req1),
        .sw_reset_ack  (ack1),
        .domain_reset  (dr1),
        .reset_done    (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_cnt++;
        end
    endtask

    // Release reset between edges so the following posedge is edge 1.
    task automatic release_reset();
        @(negedge clk);
        async_reset_n = 1'b1;
        edge_cnt      = 0;
    endtask

    task automatic test_reset();
        async_reset_n = 1'b0;
        sw_reset_req  = 1'b0;
        rst1_n        = 1'b0;
        req1          = 1'b0;
        step(3);
        checks++; if (domain_reset !== 4'b1111) $display("FAIL rst_domains: got %b want %b", domain_reset, 4'b1111); else passed++;
        checks++; if (reset_done !== 1'b0) $display("FAIL rst_done: got %b want 0", reset_done); else passed++;
        checks++; if (sw_reset_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", sw_reset_ack); else passed++;
    endtask

    task automatic test_power_on();
        release_reset();
        step(11);
        checks++; if (domain_reset !== 4'b1111) $display("FAIL por_e11: got %b want %b", domain_reset, 4'b1111); else passed++;
        step(1);
        checks++; if (domain_reset !== 4'b1110) $display("FAIL por_e12: got %b want %b", domain_reset, 4'b1110); else passed++;
        step(3);
        checks++; if (domain_reset !== 4'b1110) $display("FAIL por_e15: got %b want %b", domain_reset, 4'b1110); else passed++;
        step(1);
        checks++; if (domain_reset !== 4'b1100) $display("FAIL por_e16: got %b want %b", domain_reset, 4'b1100); else passed++;
        step(4);
        checks++; if (domain_reset !== 4'b1000) $display("FAIL por_e20: got %b want %b", domain_reset, 4'b1000); else passed++;
        step(4);
        checks++; if (domain_reset !== 4'b0000) $display("FAIL por_e24: got %b want %b", domain_reset, 4'b0000); else passed++;
        checks++; if (reset_done !== 1'b0) $display("FAIL por_done_e24: got %b want 0", reset_done); else passed++;
        step(1);
        checks++; if (reset_done !== 1'b1) $display("FAIL por_done_e25: got %b want 1", reset_done); else passed++;
    endtask

    task automatic test_async_mid();
        async_reset_n = 1'b0;
        step(2);
        release_reset();
        step(18);
        checks++; if (domain_reset !== 4'b1100) $display("FAIL mid_e18: got %b want %b", domain_reset, 4'b1100); else passed++;
        #2;
        async_reset_n = 1'b0;
        #1;
        checks++; if (domain_reset !== 4'b1111) $display("FAIL mid_async_now: got %b want %b", domain_reset, 4'b1111); else passed++;
        checks++; if (reset_done !== 1'b0) $display("FAIL mid_async_done: got %b want 0", reset_done); else passed++;
        release_reset();
        step(11);
        checks++; if (domain_reset !== 4'b1111) $display("FAIL mid_re_e11: got %b want %b", domain_reset, 4'b1111); else passed++;
        step(1);
        checks++; if (domain_reset !== 4'b1110) $display("FAIL mid_re_e12: got %b want %b", domain_reset, 4'b1110); else passed++;
        step(13);
        checks++; if (reset_done !== 1'b1) $display("FAIL mid_re_e25: got %b want 1", reset_done); else passed++;
    endtask

    // Single pulse of sw_reset_req while in DONE.
    task automatic test_sw_req();
        @(negedge clk);
        sw_reset_req = 1'b1;
        edge_cnt     = 0;
        step(1);
        sw_reset_req = 1'b0;
        checks++; if (reset_done !== 1'b0) $display("FAIL sw_done_low: got %b want 0", reset_done); else passed++;
`ifdef RST_SEQ_ORDERED_ASSERT_EN
        checks++; if (domain_reset !== 4'b1000) $display("FAIL sw_ord_e0: got %b want %b", domain_reset, 4'b1000); else passed++;
        checks++; if (sw_reset_ack !== 1'b0) $display("FAIL sw_ord_ack_e0: got %b want 0", sw_reset_ack); else passed++;
        step(4);
        checks++; if (domain_reset !== 4'b1100) $display("FAIL sw_ord_e4: got %b want %b", domain_reset, 4'b1100); else passed++;
        step(4);
        checks++; if (domain_reset !== 4'b1110) $display("FAIL sw_ord_e8: got %b want %b", domain_reset, 4'b1110); else passed++;
        step(3);
        checks++; if (sw_reset_ack !== 1'b0) $display("FAIL sw_ord_ack_e11: got %b want 0", sw_reset_ack); else passed++;
        step(1);
        checks++; if (domain_reset !== 4'b1111) $display("FAIL sw_ord_e12: got %b want %b", domain_reset, 4'b1111); else passed++;
        checks++; if (sw_reset_ack !== 1'b1) $display("FAIL sw_ord_ack_e12: got %b want 1", sw_reset_ack); else passed++;
        edge_cnt = 0;
`else
        checks++; if (domain_reset !== 4'b1111) $display("FAIL sw_e0: got %b want %b", domain_reset, 4'b1111); else passed++;
        checks++; if (sw_reset_ack !== 1'b1) $display("FAIL sw_ack_e0: got %b want 1", sw_reset_ack); else passed++;
`endif
        step(1);
        checks++; if (sw_reset_ack !== 1'b0) $display("FAIL sw_ack_pulse: got %b want 0", sw_reset_ack); else passed++;
        step(8);
        checks++; if (domain_reset !== 4'b1111) $display("FAIL sw_hold_e9: got %b want %b", domain_reset, 4'b1111); else passed++;
        step(1);
        checks++; if (domain_reset !== 4'b1110) $display("FAIL sw_e10: got %b want %b", domain_reset, 4'b1110); else passed++;
        step(4);
        checks++; if (domain_reset !== 4'b1100) $display("FAIL sw_e14: got %b want %b", domain_reset, 4'b1100); else passed++;
        step(8);
        checks++; if (domain_reset !== 4'b0000) $display("FAIL sw_e22: got %b want %b", domain_reset, 4'b0000); else passed++;
        step(1);
        checks++; if (reset_done !== 1'b1) $display("FAIL sw_done_e23: got %b want 1", reset_done); else passed++;
    endtask

    // Request held high from power-on: ignored until DONE, then one ack per sequence.
    task automatic test_req_held();
        int ack_count;
        int first_ack;
        int second_ack;
        int exp_first;
        int exp_second;
        int exp_count;
        logic [3:0] dr_e12;
        ack_count  = 0;
        first_ack  = -1;
        second_ack = -1;
        dr_e12     = 4'bxxxx;
`ifdef RST_SEQ_ORDERED_ASSERT_EN
        exp_first  = 38;
        exp_second = 74;
        exp_count  = 2;
`else
        exp_first  = 26;
        exp_second = 50;
        exp_count  = 3;
`endif
        async_reset_n = 1'b0;
        sw_reset_req  = 1'b1;
        step(2);
        release_reset();
        for (int e = 1; e <= 80; e++) begin
            step(1);
            if (edge_cnt == 12) dr_e12 = domain_reset;
            if (sw_reset_ack === 1'b1) begin
                ack_count++;
                if (first_ack < 0) first_ack = edge_cnt;
                else if (second_ack < 0) second_ack = edge_cnt;
            end
        end
        sw_reset_req = 1'b0;
        checks++; if (dr_e12 !== 4'b1110) $display("FAIL held_e12: got %b want %b", dr_e12, 4'b1110); else passed++;
        checks++; if (first_ack != exp_first) $display("FAIL held_first_ack: edge %0d want %0d", first_ack, exp_first); else passed++;
        checks++; if (second_ack != exp_second) $display("FAIL held_second_ack: edge %0d want %0d", second_ack, exp_second); else passed++;
        checks++; if (ack_count != exp_count) $display("FAIL held_ack_count: got %0d want %0d", ack_count, exp_count); else passed++;
        step(97 - edge_cnt);
        checks++; if (domain_reset !== 4'b0000) $display("FAIL held_e97_dom: got %b want %b", domain_reset, 4'b0000); else passed++;
        checks++; if (reset_done !== 1'b1) $display("FAIL held_e97_done: got %b want 1", reset_done); else passed++;
    endtask

    // Async reset and sw request together: async wins, no ack.
    task automatic test_async_priority();
        @(negedge clk);
        sw_reset_req  = 1'b1;
        async_reset_n = 1'b0;
        step(1);
        checks++; if (sw_reset_ack !== 1'b0) $display("FAIL prio_ack: got %b want 0", sw_reset_ack); else passed++;
        checks++; if (domain_reset !== 4'b1111) $display("FAIL prio_dom: got %b want %b", domain_reset, 4'b1111); else passed++;
        sw_reset_req = 1'b0;
    endtask

    task automatic test_single_domain();
        @(negedge clk);
        rst1_n   = 1'b1;
        edge_cnt = 0;
        step(3);
        checks++; if (dr1 !== 1'b1) $display("FAIL one_e3: got %b want 1", dr1); else passed++;
        step(1);
        checks++; if (dr1 !== 1'b0) $display("FAIL one_e4: got %b want 0", dr1); else passed++;
        checks++; if (done1 !== 1'b0) $display("FAIL one_done_e4: got %b want 0", done1); else passed++;
        step(1);
        checks++; if (done1 !== 1'b1) $display("FAIL one_done_e5: got %b want 1", done1); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_domain();
        test_power_on();
        test_async_mid();
        test_sw_req();
        test_req_held();
        test_async_priority();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output synchronous reset generator.
- Synchronises an async active-low reset, holds for a programmable count, then releases NUM_DOMAINS downstream reset outputs in staggered order (domain 0 first).
- Supports a software-requested re-reset of all domains without toggling the external reset.
- Sits at the top of the accelerator, driving per-block resets in order: interconnect, memory, PE array, control.

Parameters:
- NUM_DOMAINS, 4, number of reset outputs, ≥1.
- SYNC_STAGES, 2, synchroniser flop count, ≥2.
- HOLD_CYCLES, 10, cycles held after the synchroniser deasserts, before domain 0 is released, ≥1.
- STAGGER_CYCLES, 4, cycles between consecutive domain releases, ≥1.

Ports:
- clk  in  1  single system clock.
- async_reset_n  in  1  asynchronous reset, active-low.
- sw_reset_req  in  1  software re-reset request, level-sampled.
- sw_reset_ack  out  1  one-cycle pulse when a request is accepted and all domains are asserted.
- domain_reset  out  NUM_DOMAINS  per-domain synchronous reset, active-high.
- reset_done  out  1  high once every domain is released.

Behaviour:
- Reset interface: one clock; reset is asynchronous and active-low.
- While async_reset_n is low:
  - domain_reset = all ones, reset_done = 0, sw_reset_ack = 0.
  - FSM = SYNC, synchroniser = all ones, counters cleared.
- All outputs are registered.
- Synchroniser: asserts asynchronously, deasserts synchronously. Its output goes low after edge SYNC_STAGES, where edge 1 is the first rising clk edge with async_reset_n high.
- FSM states: SYNC, HOLD, RELEASE, DONE (plus ASSERT when the macro is enabled).
- SYNC -> HOLD when the synchroniser output is low.
- HOLD: counts HOLD_CYCLES cycles. domain_reset[0] drops after edge SYNC_STAGES+HOLD_CYCLES. Then -> RELEASE.
- RELEASE: domain_reset[i] drops after edge SYNC_STAGES+HOLD_CYCLES+i*STAGGER_CYCLES. After the last domain drops, -> DONE on the next edge.
- DONE: reset_done rises 1 edge after the last domain release. Defaults give release at edges 12/16/20/24 and reset_done at edge 25.
- NUM_DOMAINS=1: reset_done rises one edge after domain 0 release; no stagger wait.
- Released domains stay low until re-reset. No domain is ever released out of order.
- sw_reset_req is honoured only in DONE and ignored in every other state (no ack, no effect).
- Accepted request (default, no macro), at the next edge:
  - all domain_reset bits go high, reset_done goes low, sw_reset_ack pulses for 1 cycle.
  - FSM -> HOLD, skipping SYNC. The release sequence repeats with identical HOLD/STAGGER timing from that edge.
- A request held high continuously causes back-to-back sequences. Each sequence produces exactly one ack.
- async_reset_n asserted mid-sequence (any state): immediate full reset; the sequence restarts from SYNC.
- async_reset_n and sw_reset_req active together: async reset wins.
- Counter width: $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). Domain index width: $clog2(NUM_DOMAINS)+1. No wrap: counters load on state entry and stop at terminal count.

Optional Feature:
- Macro RST_SEQ_ORDERED_ASSERT_EN.
- When defined, an accepted sw request enters state ASSERT:
  - domain_reset[NUM_DOMAINS-1] rises at the next edge, then each lower domain follows STAGGER_CYCLES apart (reverse order).
  - sw_reset_ack pulses on the edge domain 0 asserts, then -> HOLD.
- When undefined, all domains assert simultaneously as described above. The ASSERT state and its logic are absent.
- Power-on/async reset behaviour is identical in both builds.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum seq_state_e {SYNC, HOLD, RELEASE, ASSERT, DONE}.
  - localparam helper function for counter width.
- Sub-module reset_synchronizer (param SYNC_STAGES; ports clk, async_reset_n, rst_sync_out). Reused elsewhere for CDC of resets.

Test Plan:
- Power-on, defaults: release async_reset_n -> domain_reset 4'b1110 after edge 12, 1100@16, 1000@20, 0000@24; reset_done=1 after edge 25.
- async_reset_n pulsed low at edge 18 (domains 0,1 released) -> domain_reset=4'b1111 immediately, reset_done=0; after re-release, full sequence repeats from edge 1.
- In DONE, 1-cycle sw_reset_req -> next edge domain_reset=4'b1111, sw_reset_ack=1 for exactly 1 cycle; domain 0 drops 10 edges later, then every 4 edges.
- sw_reset_req high during HOLD/RELEASE -> no ack, sequence timing unchanged. sw_reset_req held high permanently -> one ack per completed sequence.
- NUM_DOMAINS=1, HOLD_CYCLES=1, SYNC_STAGES=3 -> domain_reset drops after edge 4, reset_done after edge 5.
- RST_SEQ_ORDERED_ASSERT_EN defined, sw request in DONE -> domain_reset 1000, 1100 (+4), 1110 (+8), 1111 (+12) with ack on the 1111 edge; release order unchanged.
